// File: rtl/ps2_lane_mapper.sv
// ps2_lane_mapper: maps PS/2 make/break scancodes and synchronised push-buttons
// onto game input lanes. Each lane gets a registered pressed level, one-cycle
// press and release strobes, and a saturating count of cycles held.
module ps2_lane_mapper #(
    parameter int                       NUM_LANES      = 6,
    parameter logic [NUM_LANES*8-1:0]   SCANCODES      = {8'h7A, 8'h72, 8'h69, 8'h74, 8'h73, 8'h6B},
    parameter int                       HOLD_W         = 8,
    parameter bit                       OUT_ACTIVE_LOW = 1'b1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          valid,
    input  logic                          makeBreak,
    input  logic [7:0]                    outCode,
    input  logic [NUM_LANES-1:0]          key_n,
    output logic [NUM_LANES-1:0]          user_press,
    output logic [NUM_LANES-1:0]          press_pulse,
    output logic [NUM_LANES-1:0]          release_pulse,
    output logic [NUM_LANES*HOLD_W-1:0]   hold_count,
    output logic                          any_press
);

    localparam logic [HOLD_W-1:0] HOLD_MAX  = {HOLD_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};

    // Saturating increment: the counter sticks at its maximum instead of wrapping.
    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        if (v == HOLD_MAX) begin
            return v;
        end else begin
            return v + HOLD_ONE;
        end
    endfunction

    logic [NUM_LANES-1:0]             match_s;
    logic [NUM_LANES-1:0]             kb_next_s;
    logic [NUM_LANES-1:0]             kb_held_r;
    logic [NUM_LANES-1:0]             key_meta_r;
    logic [NUM_LANES-1:0]             key_stage2_r;
    logic [NUM_LANES-1:0]             key_sync_s;
    logic [NUM_LANES-1:0]             pressed_s;
    logic [NUM_LANES-1:0]             prev_r;
    logic [NUM_LANES-1:0]             user_press_r;
    logic [NUM_LANES-1:0]             press_pulse_r;
    logic [NUM_LANES-1:0]             release_pulse_r;
    logic                             any_press_r;
    logic [NUM_LANES-1:0][HOLD_W-1:0] hold_cnt_r;

    // Compare the incoming scancode against every lane; duplicate codes may match several lanes.
    always_comb begin
        match_s = {NUM_LANES{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            match_s[i] = (outCode == SCANCODES[8*i +: 8]);
        end
    end

    // Next keyboard-held state: matching lanes take makeBreak on a valid strobe, all others hold.
    always_comb begin
        kb_next_s = kb_held_r;
        if (valid) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (match_s[i]) begin
                    kb_next_s[i] = makeBreak;
                end else begin
                    kb_next_s[i] = kb_held_r[i];
                end
            end
        end else begin
            kb_next_s = kb_held_r;
        end
    end

    // Keyboard-held register per lane.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            kb_held_r <= {NUM_LANES{1'b0}};
        end else begin
            kb_held_r <= kb_next_s;
        end
    end

    // Two-flop synchroniser for the asynchronous active-low push-buttons; resets to released (high).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_meta_r   <= {NUM_LANES{1'b1}};
            key_stage2_r <= {NUM_LANES{1'b1}};
        end else begin
            key_meta_r   <= key_n;
            key_stage2_r <= key_meta_r;
        end
    end

    assign key_sync_s = ~key_stage2_r;
    assign pressed_s  = kb_held_r | key_sync_s;

    // Registered lane level, edge strobes and any-press flag, all one cycle behind pressed_s.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_r          <= {NUM_LANES{1'b0}};
            user_press_r    <= {NUM_LANES{OUT_ACTIVE_LOW}};
            press_pulse_r   <= {NUM_LANES{1'b0}};
            release_pulse_r <= {NUM_LANES{1'b0}};
            any_press_r     <= 1'b0;
        end else begin
            prev_r          <= pressed_s;
            user_press_r    <= OUT_ACTIVE_LOW ? ~pressed_s : pressed_s;
            press_pulse_r   <= pressed_s & ~prev_r;
            release_pulse_r <= ~pressed_s & prev_r;
            any_press_r     <= |pressed_s;
        end
    end

    // Per-lane hold counter: counts cycles pressed, saturates, clears whenever the lane is released.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_cnt_r <= {NUM_LANES{HOLD_ZERO}};
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (pressed_s[i]) begin
                    hold_cnt_r[i] <= sat_inc(hold_cnt_r[i]);
                end else begin
                    hold_cnt_r[i] <= HOLD_ZERO;
                end
            end
        end
    end

    assign user_press    = user_press_r;
    assign press_pulse   = press_pulse_r;
    assign release_pulse = release_pulse_r;
    assign any_press     = any_press_r;
    assign hold_count    = hold_cnt_r;

endmodule

// File: doc/ps2_lane_mapper.md
PS2_LANE_MAPPER -- requirements
Module: ps2_lane_mapper

Interface
REQ-001 Parameter NUM_LANES, default 6: number of game input lanes (1..16).
REQ-002 Parameter SCANCODES, default {8'h7A,8'h72,8'h69,8'h74,8'h73,8'h6B}: packed NUM_LANES*8 bits; lane i code at bits [8i+7:8i].
REQ-003 Parameter HOLD_W, default 8: width of the per-lane hold counter.
REQ-004 Parameter OUT_ACTIVE_LOW, default 1: 1 = user_press is 0 when pressed; 0 = user_press is 1 when pressed.
REQ-005 clk  input  1: single system clock; all state changes on its rising edge.
REQ-006 resetn  input  1: synchronous, active-low reset.
REQ-007 valid  input  1: one-cycle strobe; makeBreak and outCode are valid when high.
REQ-008 makeBreak  input  1: 1 = make (key down), 0 = break (key up).
REQ-009 outCode  input  8: PS/2 scancode.
REQ-010 key_n  input  NUM_LANES: asynchronous push-buttons, active-low, OR-ed into lane state.
REQ-011 user_press  output  NUM_LANES: registered lane-pressed level, polarity per OUT_ACTIVE_LOW.
REQ-012 press_pulse  output  NUM_LANES: one-cycle strobe on the lane-pressed rising edge.
REQ-013 release_pulse  output  NUM_LANES: one-cycle strobe on the lane-pressed falling edge.
REQ-014 hold_count  output  NUM_LANES*HOLD_W: per-lane cycles-held count; lane i at [HOLD_W*i+HOLD_W-1:HOLD_W*i].
REQ-015 any_press  output  1: high when any lane is pressed.

Function
REQ-016 kb_held[i] shall be set on the edge where valid=1, makeBreak=1 and outCode == SCANCODES lane i.
REQ-017 kb_held[i] shall be cleared on the edge where valid=1, makeBreak=0 and outCode == SCANCODES lane i.
REQ-018 Duplicate codes in SCANCODES: every matching lane shall update; codes matching no lane shall change no state.
REQ-019 key_n shall pass through a 2-flop synchroniser; key_sync[i] = inverted second-stage output.
REQ-020 pressed[i] = kb_held[i] OR key_sync[i], combinational from registers; prev[i] shall be a registered copy of pressed[i].
REQ-021 user_press, press_pulse, release_pulse and any_press shall be registered, one cycle after pressed changes; a scancode therefore reaches user_press 2 cycles after its valid edge.
REQ-022 press_pulse[i] = pressed[i] AND NOT prev[i], registered; high for exactly one cycle per rising edge.
REQ-023 release_pulse[i] = NOT pressed[i] AND prev[i], registered; high for exactly one cycle per falling edge.
REQ-024 Typematic repeat makes (make while already held): no pulse, hold_count unaffected.
REQ-025 Break for a lane still held by key_sync: no release_pulse; the lane stays pressed.
REQ-026 hold_count[i]: cleared to 0 in any cycle where pressed[i]=0.
REQ-027 hold_count[i]: +1 per cycle while pressed[i]=1.
REQ-028 hold_count[i]: saturates at 2^HOLD_W-1 and never wraps.
REQ-029 Make and break on consecutive valid cycles: press_pulse then release_pulse on consecutive cycles; hold_count peaks at 1.
REQ-030 valid=0: kb_held shall hold its value regardless of makeBreak and outCode.

Reset
REQ-031 While resetn=0 at a clk edge, the following shall be cleared to 0: kb_held, synchroniser stages (to the released state), prev, press_pulse, release_pulse, hold_count, any_press.
REQ-032 During reset, user_press shall be all-ones if OUT_ACTIVE_LOW=1, else all-zeros.
REQ-033 Reset mid-hold: no release_pulse.
REQ-034 After reset, a lane held at release shall need a fresh make or a synchronised key_n low to press again.
REQ-035 The first edge after resetn returns high shall perform normal operation.

Verification
REQ-036 Defaults; valid pulse make 8'h6B -> user_press[0]=0 two cycles later, press_pulse=6'b000001 for one cycle, any_press=1.
REQ-037 Hold lane 2 (8'h74) 300 cycles, HOLD_W=8 -> hold_count lane 2 reaches 255 and holds; break -> release_pulse[2] for one cycle, count returns to 0.
REQ-038 Make 8'h73, then three repeat makes of 8'h73 -> exactly one press_pulse[1].
REQ-039 key_n[3]=0 and kb make 8'h69, then break 8'h69 -> lane 3 stays pressed with no release_pulse until key_n[3]=1.
REQ-040 Make 8'h7A, then assert resetn=0 one cycle -> all outputs at reset values, no release_pulse, lane 5 released.
REQ-041 NUM_LANES=3, SCANCODES={8'h1C,8'h1C,8'h1B}, make 8'h1C -> press_pulse=3'b110; make 8'h5A -> no change.
